serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, one bit per clock, LSB first.
// z/co are architectural registers updated only when the last bit is added.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             co
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, y_q, sum_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic             s_bit, c_bit, last;
    logic [WIDTH-1:0] sum_next;

    full_adder u_fa (
        .a  (x_q[0]),
        .b  (y_q[0]),
        .c  (c_q),
        .s  (s_bit),
        .co (c_bit)
    );

    assign last     = (cnt_q == CW'(WIDTH - 1));
    assign sum_next = {s_bit, sum_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = ADD;
            ADD: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            sum_q <= '0;
            c_q   <= 1'b0;
            cnt_q <= '0;
            z     <= '0;
            co    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    x_q   <= x;
                    y_q   <= y;
                    c_q   <= ci;
                    cnt_q <= '0;
                end
                ADD: begin
                    sum_q <= sum_next;
                    x_q   <= x_q >> 1;
                    y_q   <= y_q >> 1;
                    c_q   <= c_bit;
                    cnt_q <= cnt_q + CW'(1);
                    // Publish the full result only once every bit has been summed
                    if (last) begin
                        z  <= sum_next;
                        co <= c_bit;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk, rst_n, start, ci;
    logic [W-1:0] x, y;
    logic         busy, done, co;
    logic [W-1:0] z;

    int pass_cnt  = 0;
    int total_cnt = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; x = '0; y = '0; ci = 1'b0;
        #12;
        total_cnt++;
        if ({busy, done, co, z} !== 11'b0)
            $display("FAIL reset_state: busy=%b done=%b co=%b z=%h, required all 0", busy, done, co, z);
        else pass_cnt++;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_add(input string name, input logic [W-1:0] xa, input logic [W-1:0] ya,
                            input logic ca, input logic [W-1:0] ez, input logic eco);
        logic [W-1:0] pz;
        logic         pco;
        pz = z; pco = co;
        x = xa; y = ya; ci = ca; start = 1'b1;
        tick;
        start = 1'b0; x = ~xa; y = ya ^ 8'h5A; ci = ~ca;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_accept: busy=%b, required 1", name, busy);
        else pass_cnt++;
        for (int k = 1; k <= W; k++) begin
            tick;
            if (k < W) begin
                total_cnt++;
                if (busy !== 1'b1 || done !== 1'b0 || z !== pz || co !== pco)
                    $display("FAIL %s add_cycle%0d: busy=%b done=%b z=%h co=%b, required busy=1 done=0 z=%h co=%b",
                             name, k, busy, done, z, co, pz, pco);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s done_timing: done=%b busy=%b, required done=1 busy=0", name, done, busy);
        else pass_cnt++;
        total_cnt++;
        if (z !== ez || co !== eco)
            $display("FAIL %s result: z=%h co=%b, required z=%h co=%b", name, z, co, ez, eco);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s back_to_idle: done=%b busy=%b, required 0 0", name, done, busy);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored;
        int           ndone;
        logic [W-1:0] rz;
        logic         rco;
        ndone = 0; rz = '0; rco = 1'b0;
        x = 8'h3C; y = 8'h5A; ci = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        x = 8'h11; y = 8'h22; ci = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick;
            if (done) begin ndone++; rz = z; rco = co; end
        end
        total_cnt++;
        if (ndone !== 1) $display("FAIL ignore_start_pulses: got %0d done pulses, required 1", ndone);
        else pass_cnt++;
        total_cnt++;
        if (rz !== 8'h96 || rco !== 1'b0)
            $display("FAIL ignore_start_result: z=%h co=%b, required z=96 co=0", rz, rco);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int ndone;
        ndone = 0;
        x = 8'h3C; y = 8'h5A; ci = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, co, z} !== 11'b0)
            $display("FAIL reset_mid_add: busy=%b done=%b co=%b z=%h, required all 0", busy, done, co, z);
        else pass_cnt++;
        tick;
        tick;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (done) ndone++;
        end
        total_cnt++;
        if (ndone !== 0) $display("FAIL reset_mid_no_done: got %0d done pulses, required 0", ndone);
        else pass_cnt++;
        test_add("after_reset", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ox[3]  = '{8'h3C, 8'hFF, 8'h80};
        logic [W-1:0] oy[3]  = '{8'h5A, 8'h01, 8'h7F};
        logic         oc[3]  = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] ez[3]  = '{8'h96, 8'h00, 8'h00};
        logic         eco[3] = '{1'b0, 1'b1, 1'b1};
        int n, idle;
        n = 0; idle = 0;
        x = ox[0]; y = oy[0]; ci = oc[0]; start = 1'b1;
        tick;
        for (int cyc = 1; cyc <= 40 && n < 3; cyc++) begin
            tick;
            if (!busy && !done) idle++;
            if (done) begin
                total_cnt++;
                if (z !== ez[n] || co !== eco[n])
                    $display("FAIL b2b_result%0d: z=%h co=%b, required z=%h co=%b", n, z, co, ez[n], eco[n]);
                else pass_cnt++;
                total_cnt++;
                if (cyc !== 8 + 10 * n)
                    $display("FAIL b2b_timing%0d: done at cycle %0d, required %0d", n, cyc, 8 + 10 * n);
                else pass_cnt++;
                if (n > 0) begin
                    total_cnt++;
                    if (idle !== 1) $display("FAIL b2b_idle%0d: %0d idle cycles, required 1", n, idle);
                    else pass_cnt++;
                end
                idle = 0;
                n++;
                if (n < 3) begin x = ox[n]; y = oy[n]; ci = oc[n]; end
                else start = 1'b0;
            end
        end
        start = 1'b0;
        total_cnt++;
        if (n !== 3) $display("FAIL b2b_count: got %0d results, required 3", n);
        else pass_cnt++;
        tick;
    endtask

    task automatic test_random;
        logic [W-1:0] xa, ya, pz;
        logic         ca, pco, got, stable;
        logic [W:0]   exp_sum;
        for (int i = 0; i < 1000; i++) begin
            xa = W'($urandom); ya = W'($urandom); ca = 1'($urandom);
            exp_sum = {1'b0, xa} + {1'b0, ya} + {{W{1'b0}}, ca};
            pz = z; pco = co;
            x = xa; y = ya; ci = ca; start = 1'b1;
            tick;
            start = 1'b0; x = $urandom; y = $urandom;
            got = 1'b0; stable = 1'b1;
            for (int k = 0; k < 12 && !got; k++) begin
                tick;
                if (done) got = 1'b1;
                else if (z !== pz || co !== pco) stable = 1'b0;
            end
            total_cnt++;
            if (got !== 1'b1) $display("FAIL rand%0d_timeout: no done within 12 cycles", i);
            else pass_cnt++;
            total_cnt++;
            if ({co, z} !== exp_sum)
                $display("FAIL rand%0d_sum: x=%h y=%h ci=%b got %h, required %h", i, xa, ya, ca, {co, z}, exp_sum);
            else pass_cnt++;
            total_cnt++;
            if (stable !== 1'b1) $display("FAIL rand%0d_stable: z/co moved before done", i);
            else pass_cnt++;
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_add("basic_3c_5a", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0);
        test_add("ff_plus_01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        test_add("zero_ci",     8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        test_add("aa_55_ci",    8'hAA, 8'h55, 1'b1, 8'h00, 1'b1);
        test_start_ignored;
        test_add("ff_ff_ci",    8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
